// File: rtl/aes_axi_lite_regs_if.sv
// AXI4-Lite bus bundle for the AES register block (S00_AXI).
// The slave modport is the register block's view; the master modport is the bus driver's view.
interface aes_axi_lite_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
);
    // write address channel
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    // write data channel
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    // write response channel
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    // read address channel
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    // read data channel
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/aes_axi_lite_regs.sv
// AXI4-Lite register block for the AES core: key/plaintext registers,
// start/busy/done control and ciphertext capture. Word map (addr[5:2]):
// 0 CTRL, 1 STATUS, 4-7 KEY0..3, 8-11 DIN0..3, 12-15 DOUT0..3.
module aes_axi_lite_regs (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
    aes_axi_lite_regs_if.slave  s_axi,
    output logic [127:0]        aes_key,
    output logic [127:0]        aes_din,
    output logic                aes_start,
    input  logic                aes_done,
    input  logic [127:0]        aes_dout
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] IDX_CTRL    = 4'd0;
    localparam logic [3:0] IDX_STATUS  = 4'd1;
    localparam logic [1:0] GRP_KEY     = 2'b01;
    localparam logic [1:0] GRP_DIN     = 2'b10;
    localparam logic [1:0] GRP_DOUT    = 2'b11;

    // Ready outputs stay low until the first edge after reset release.
    logic        r_rdy_en;

    // write channel state
    logic        r_aw_held;
    logic        r_w_held;
    logic [3:0]  r_aw_idx;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_bvalid;
    logic [1:0]  r_bresp;

    // read channel state
    logic        r_rvalid;
    logic [31:0] r_rdata;

    // core control and register file
    logic        r_busy;
    logic        r_done;
    logic        r_start;
    logic [31:0] r_key  [4];
    logic [31:0] r_din  [4];
    logic [31:0] r_dout [4];

    logic        w_awready;
    logic        w_wready;
    logic        w_arready;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_commit;
    logic [3:0]  w_wr_idx;
    logic [31:0] w_wr_data;
    logic [3:0]  w_wr_strb;
    logic        w_wr_keydin;
    logic        w_wr_err;
    logic        w_start_req;
    logic        w_done_ok;
    logic [3:0]  w_rd_idx;
    logic [31:0] w_rd_data;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic        w_unused;
    assign w_unused = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    assign w_awready = r_rdy_en & ~r_aw_held & ~r_bvalid;
    assign w_wready  = r_rdy_en & ~r_w_held  & ~r_bvalid;
    assign w_arready = r_rdy_en & ~r_rvalid;

    assign w_aw_hs = s_axi.S_AXI_AWVALID & w_awready;
    assign w_w_hs  = s_axi.S_AXI_WVALID  & w_wready;

    // A write commits on the edge where the later of the two halves arrives.
    // Both flags are only ever set together while BVALID is high, so ~r_bvalid
    // keeps a finished transaction from committing twice.
    assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs) & ~r_bvalid;

    assign w_wr_idx  = r_aw_held ? r_aw_idx : s_axi.S_AXI_AWADDR[5:2];
    assign w_wr_data = r_w_held  ? r_wdata  : s_axi.S_AXI_WDATA;
    assign w_wr_strb = r_w_held  ? r_wstrb  : s_axi.S_AXI_WSTRB;

    assign w_wr_keydin = (w_wr_idx[3:2] == GRP_KEY) || (w_wr_idx[3:2] == GRP_DIN);
    assign w_wr_err    = w_commit & w_wr_keydin & r_busy;
    assign w_start_req = w_commit & (w_wr_idx == IDX_CTRL) & w_wr_data[0]
                       & w_wr_strb[0] & ~r_busy;
    // Start requires busy=0 and completion requires busy=1, so they never coincide.
    assign w_done_ok   = aes_done & r_busy;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    // Write address/data capture and write response generation.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rdy_en  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            // NOTE: non-blocking assignments on every flop so all state updates
            // see the pre-edge values, independent of block evaluation order.
            r_rdy_en <= 1'b1;
            if (r_bvalid) begin
                if (s_axi.S_AXI_BREADY) begin
                    r_bvalid  <= 1'b0;
                    r_bresp   <= RESP_OKAY;
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                end
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_idx  <= s_axi.S_AXI_AWADDR[5:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s_axi.S_AXI_WDATA;
                    r_wstrb  <= s_axi.S_AXI_WSTRB;
                end
                if (w_commit) begin
                    r_bvalid <= 1'b1;
                    r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // KEY and DIN registers: byte-lane writes, dropped while the core is busy.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            // NOTE: these small arrays are plain flops, and the outputs must read
            // zero after reset, so every entry is reset rather than left as RAM.
            for (int i = 0; i < 4; i++) begin
                r_key[i] <= '0;
                r_din[i] <= '0;
            end
        end else if (w_commit && !r_busy) begin
            if (w_wr_idx[3:2] == GRP_KEY)
                r_key[w_wr_idx[1:0]] <= merge_bytes(r_key[w_wr_idx[1:0]], w_wr_data, w_wr_strb);
            else if (w_wr_idx[3:2] == GRP_DIN)
                r_din[w_wr_idx[1:0]] <= merge_bytes(r_din[w_wr_idx[1:0]], w_wr_data, w_wr_strb);
        end
    end

    // Start pulse, busy/done tracking and ciphertext capture.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < 4; i++) r_dout[i] <= '0;
        end else begin
            r_start <= w_start_req;
            if (w_start_req) begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end else if (w_done_ok) begin
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_dout[0] <= aes_dout[127:96];
                r_dout[1] <= aes_dout[95:64];
                r_dout[2] <= aes_dout[63:32];
                r_dout[3] <= aes_dout[31:0];
            end
        end
    end

    // Read mux over the current register state.
    assign w_rd_idx = s_axi.S_AXI_ARADDR[5:2];
    always_comb begin
        // NOTE: default first so every path assigns w_rd_data and no latch is inferred.
        w_rd_data = '0;
        case (w_rd_idx[3:2])
            GRP_KEY:  w_rd_data = r_key[w_rd_idx[1:0]];
            GRP_DIN:  w_rd_data = r_din[w_rd_idx[1:0]];
            GRP_DOUT: w_rd_data = r_dout[w_rd_idx[1:0]];
            default:  if (w_rd_idx == IDX_STATUS) w_rd_data = {30'd0, r_done, r_busy};
        endcase
    end

    // Read channel: register data at the AR handshake, hold until RREADY.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (r_rvalid) begin
            if (s_axi.S_AXI_RREADY) r_rvalid <= 1'b0;
        end else if (s_axi.S_AXI_ARVALID && w_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
        end
    end

    assign s_axi.S_AXI_AWREADY = w_awready;
    assign s_axi.S_AXI_WREADY  = w_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = w_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

    assign aes_key   = {r_key[0], r_key[1], r_key[2], r_key[3]};
    assign aes_din   = {r_din[0], r_din[1], r_din[2], r_din[3]};
    assign aes_start = r_start;
endmodule

// File: tb/tb_aes_axi_lite_regs.sv
// Directed bench for aes_axi_lite_regs. Bus tasks push the expected
// response into a queue; a monitor pops and compares on each B/R handshake.
`timescale 1ns/1ps
module tb_aes_axi_lite_regs;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         aes_done = 1'b0;
    logic [127:0] aes_dout = '0;
    logic [127:0] aes_key;
    logic [127:0] aes_din;
    logic         aes_start;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;

    logic [1:0]  b_q [$];
    logic [31:0] r_q [$];

    always #5 clk = ~clk;

    aes_axi_lite_regs_if bus ();

    aes_axi_lite_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus),
        .aes_key       (aes_key),
        .aes_din       (aes_din),
        .aes_start     (aes_start),
        .aes_done      (aes_done),
        .aes_dout      (aes_dout)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // count cycles in which aes_start is high
    always @(negedge clk) if (aes_start === 1'b1) start_cnt++;

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
            if (b_q.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected: got bresp %h, expected no response", bus.S_AXI_BRESP);
            end else begin
                check("bresp", 128'(bus.S_AXI_BRESP), 128'(b_q.pop_front()));
            end
        end
        if (rst_n && bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
            if (r_q.size() == 0) begin
                total++; bad++;
                $display("FAIL r_unexpected: got rdata %h, expected no response", bus.S_AXI_RDATA);
            end else begin
                check("rdata", 128'(bus.S_AXI_RDATA), 128'(r_q.pop_front()));
                check("rresp", 128'(bus.S_AXI_RRESP), 128'd0);
            end
        end
    end

    // Drive AW and/or W and wait until each offered half is accepted.
    task automatic addr_data(input logic do_aw, input logic do_w, input logic [5:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
        logic aw_pend;
        logic w_pend;
        logic aw_acc;
        logic w_acc;
        int   n;
        aw_pend = do_aw;
        w_pend  = do_w;
        n = 0;
        if (do_aw) begin bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1; end
        if (do_w)  begin bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1; end
        while ((aw_pend || w_pend) && n < 50) begin
            @(negedge clk);
            aw_acc = aw_pend && bus.S_AXI_AWREADY;
            w_acc  = w_pend  && bus.S_AXI_WREADY;
            @(posedge clk); #1;
            if (aw_acc) begin bus.S_AXI_AWVALID = 1'b0; aw_pend = 1'b0; end
            if (w_acc)  begin bus.S_AXI_WVALID  = 1'b0; w_pend  = 1'b0; end
            n++;
        end
        if (aw_pend || w_pend) begin
            timeout("aw_w_accept");
            bus.S_AXI_AWVALID = 1'b0;
            bus.S_AXI_WVALID  = 1'b0;
        end
    endtask

    // order: 0 = AW then W, 1 = W then AW, 2 = same cycle
    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int order, input logic [1:0] exp_resp, input int hold);
        int n;
        b_q.push_back(exp_resp);
        case (order)
            0: begin addr_data(1'b1, 1'b0, addr, data, strb); addr_data(1'b0, 1'b1, addr, data, strb); end
            1: begin addr_data(1'b0, 1'b1, addr, data, strb); addr_data(1'b1, 1'b0, addr, data, strb); end
            default: addr_data(1'b1, 1'b1, addr, data, strb);
        endcase
        n = 0;
        @(negedge clk);
        while (!bus.S_AXI_BVALID && n < 50) begin @(negedge clk); n++; end
        if (!bus.S_AXI_BVALID) begin
            timeout("bvalid");
            void'(b_q.pop_back());
        end else begin
            for (int i = 0; i < hold; i++) begin
                check("bvalid_hold",  128'(bus.S_AXI_BVALID),  128'd1);
                check("bresp_hold",   128'(bus.S_AXI_BRESP),   128'(exp_resp));
                check("awready_hold", 128'(bus.S_AXI_AWREADY), 128'd0);
                check("wready_hold",  128'(bus.S_AXI_WREADY),  128'd0);
                @(negedge clk);
            end
            @(posedge clk); #1 bus.S_AXI_BREADY = 1'b1;
            @(posedge clk); #1 bus.S_AXI_BREADY = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [5:0] addr, input logic [31:0] exp_data, input int hold);
        int n;
        r_q.push_back(exp_data);
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.S_AXI_ARVALID = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.S_AXI_RVALID && n < 50) begin @(negedge clk); n++; end
        if (!bus.S_AXI_RVALID) begin
            timeout("rvalid");
            void'(r_q.pop_back());
        end else begin
            for (int i = 0; i < hold; i++) begin
                check("rvalid_hold",  128'(bus.S_AXI_RVALID),  128'd1);
                check("rdata_hold",   128'(bus.S_AXI_RDATA),   128'(exp_data));
                check("arready_hold", 128'(bus.S_AXI_ARREADY), 128'd0);
                @(negedge clk);
            end
            @(posedge clk); #1 bus.S_AXI_RREADY = 1'b1;
            @(posedge clk); #1 bus.S_AXI_RREADY = 1'b0;
        end
    endtask

    task automatic pulse_done(input logic [127:0] dout);
        @(posedge clk); #1;
        aes_done = 1'b1;
        aes_dout = dout;
        @(posedge clk); #1;
        aes_done = 1'b0;
    endtask

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    initial begin
        logic [31:0] key_tab [4];
        logic [31:0] dout_tab [4];
        int s0;
        key_tab  = '{32'h2B7E1516, 32'h28AED2A6, 32'hABF71588, 32'h09CF4F3C};
        dout_tab = '{32'h3925841D, 32'h02DC09FB, 32'hDC118597, 32'h196A0B32};

        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;

        // reset behaviour and ready release
        repeat (3) @(negedge clk);
        check("rst_awready", 128'(bus.S_AXI_AWREADY), 128'd0);
        check("rst_wready",  128'(bus.S_AXI_WREADY),  128'd0);
        check("rst_arready", 128'(bus.S_AXI_ARREADY), 128'd0);
        rst_n = 1'b1;
        #1 check("rel_arready_pre", 128'(bus.S_AXI_ARREADY), 128'd0);
        @(negedge clk);
        check("rel_awready", 128'(bus.S_AXI_AWREADY), 128'd1);
        check("rel_wready",  128'(bus.S_AXI_WREADY),  128'd1);
        check("rel_arready", 128'(bus.S_AXI_ARREADY), 128'd1);

        axi_read(6'h04, 32'h0, 0);
        axi_read(6'h10, 32'h0, 0);
        axi_read(6'h3C, 32'h0, 0);

        // key writes with all three AW/W orderings
        for (int i = 0; i < 4; i++)
            axi_write(6'(6'h10 + 4*i), key_tab[i], 4'hF, i % 3, OKAY, 0);
        for (int i = 0; i < 4; i++)
            axi_read(6'(6'h10 + 4*i), key_tab[i], 0);
        check("aes_key", aes_key, 128'h2B7E151628AED2A6ABF7158809CF4F3C);

        // byte-lane write
        axi_write(6'h20, 32'h11223344, 4'hF, 2, OKAY, 0);
        axi_write(6'h20, 32'hFFFFFFFF, 4'b0010, 0, OKAY, 0);
        axi_read(6'h20, 32'h1122FF44, 0);
        check("aes_din0", aes_din[127:96], 128'h1122FF44);

        // start
        s0 = start_cnt;
        axi_write(6'h00, 32'h1, 4'hF, 2, OKAY, 0);
        check("start_pulses", start_cnt - s0, 1);
        axi_read(6'h04, 32'h1, 0);
        axi_read(6'h00, 32'h0, 0);

        // writes while busy
        axi_write(6'h14, 32'hCAFEF00D, 4'hF, 2, SLVERR, 0);
        axi_read(6'h14, 32'h28AED2A6, 0);
        s0 = start_cnt;
        axi_write(6'h00, 32'h1, 4'hF, 1, OKAY, 0);
        check("restart_ignored", start_cnt - s0, 0);
        axi_read(6'h04, 32'h1, 0);

        // completion
        pulse_done(128'h3925841D02DC09FBDC118597196A0B32);
        axi_read(6'h04, 32'h2, 0);
        for (int i = 0; i < 4; i++)
            axi_read(6'(6'h30 + 4*i), dout_tab[i], 0);
        pulse_done({4{32'hFFFFFFFF}});
        axi_read(6'h30, 32'h3925841D, 0);
        axi_read(6'h04, 32'h2, 0);

        // back-pressure on B and R
        axi_write(6'h24, 32'hDEADBEEF, 4'hF, 2, OKAY, 5);
        axi_read(6'h24, 32'hDEADBEEF, 5);

        // reset while busy with an address-only write pending
        s0 = start_cnt;
        axi_write(6'h00, 32'h1, 4'hF, 2, OKAY, 0);
        check("start2_pulses", start_cnt - s0, 1);
        addr_data(1'b1, 1'b0, 6'h10, 32'h0, 4'h0);
        check("half_wready", 128'(bus.S_AXI_AWREADY), 128'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_awready", 128'(bus.S_AXI_AWREADY), 128'd0);
        check("mid_rst_wready",  128'(bus.S_AXI_WREADY),  128'd0);
        check("mid_rst_arready", 128'(bus.S_AXI_ARREADY), 128'd0);
        check("mid_rst_bvalid",  128'(bus.S_AXI_BVALID),  128'd0);
        check("mid_rst_rvalid",  128'(bus.S_AXI_RVALID),  128'd0);
        check("mid_rst_bresp",   128'(bus.S_AXI_BRESP),   128'd0);
        check("mid_rst_rdata",   128'(bus.S_AXI_RDATA),   128'd0);
        check("mid_rst_start",   128'(aes_start),         128'd0);
        check("mid_rst_key",     aes_key,                 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        axi_read(6'h04, 32'h0, 0);
        axi_read(6'h30, 32'h0, 0);
        s0 = start_cnt;
        axi_write(6'h00, 32'h1, 4'hF, 0, OKAY, 0);
        check("start3_pulses", start_cnt - s0, 1);
        axi_read(6'h04, 32'h1, 0);

        repeat (2) @(negedge clk);
        check("b_q_drained", 128'(b_q.size()), 128'd0);
        check("r_q_drained", 128'(r_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // overall time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
